// File: rtl/toycpu_pkg.sv
// Shared opcodes, instruction field positions, FSM states and decode types
// for the toy CPU control unit.
package toycpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_LDI  = 6'd1;
    localparam logic [5:0] OP_JZ   = 6'd2;
    localparam logic [5:0] OP_JC   = 6'd3;
    localparam logic [5:0] OP_JMP  = 6'd4;
    localparam logic [5:0] OP_HALT = 6'd5;
    localparam logic [5:0] OP_MV   = 6'd63;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 10;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LDI,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [5:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } decoded_t;

endpackage

// File: rtl/toycpu_if.sv
// Bus bundle between the control unit and its instruction memory,
// register file and ALU.
interface toycpu_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic [1:0]      rf_ra1;
    logic [1:0]      rf_ra2;
    logic            rf_we;
    logic [1:0]      rf_wa;
    logic [15:0]     rf_wd;
    logic [5:0]      alu_op;
    logic [15:0]     alu_out;
    logic            c_flag;
    logic            z_flag;

    modport master (
        output imem_req, imem_addr, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_op,
        input  imem_ack, imem_data, alu_out, c_flag, z_flag
    );

    modport slave (
        input  imem_req, imem_addr, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_op,
        output imem_ack, imem_data, alu_out, c_flag, z_flag
    );
endinterface

// File: rtl/toycpu_decode.sv
// Combinational decoder: splits the instruction register into fields and
// classifies the opcode.
module toycpu_decode
    import toycpu_pkg::*;
(
    input  logic [15:0] ir,
    output decoded_t    dec
);

    always_comb begin
        dec.op  = ir[OP_MSB:OP_LSB];
        dec.rd  = ir[RD_MSB:RD_LSB];
        dec.rs  = ir[RS_MSB:RS_LSB];
        dec.imm = ir[IMM_MSB:IMM_LSB];
        case (ir[OP_MSB:OP_LSB])
            OP_ADD, OP_MV:       dec.cls = CLS_ALU;
            OP_LDI:              dec.cls = CLS_LDI;
            OP_JZ, OP_JC, OP_JMP: dec.cls = CLS_JUMP;
            OP_HALT:             dec.cls = CLS_HALT;
            default:             dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/toycpu_ctrl.sv
// Multi-cycle control unit: FETCH -> DECODE -> (EXEC) -> (WB) sequencing of
// a 16-bit instruction stream against an external register file and ALU.
module toycpu_ctrl
    import toycpu_pkg::*;
#(
    parameter int PC_W          = 8,
    parameter int FETCH_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    toycpu_if.master        bus,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    localparam int TO_LAST = (FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0;

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ir, ir_next;
    logic [15:0]     result, result_next;
    logic            illegal_next;
    logic [31:0]     wait_cnt, wait_cnt_next;
    logic            jump_taken;
    logic            timeout;
    decoded_t        dec;

    toycpu_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    always_comb begin
        case (dec.op)
            OP_JZ:   jump_taken = bus.z_flag;
            OP_JC:   jump_taken = bus.c_flag;
            OP_JMP:  jump_taken = 1'b1;
            default: jump_taken = 1'b0;
        endcase
    end

    assign timeout = (FETCH_TIMEOUT > 0) && (wait_cnt == 32'(TO_LAST));
    assign halted  = (state == ST_HALT);

    always_comb begin
        // NOTE: every next-value and output is defaulted first so no path through the case leaves one unassigned and infers a latch.
        state_next    = state;
        pc_next       = pc;
        ir_next       = ir;
        result_next   = result;
        illegal_next  = illegal;
        wait_cnt_next = '0;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc;
        bus.rf_ra1    = dec.rd;
        bus.rf_ra2    = dec.rs;
        bus.rf_we     = 1'b0;
        bus.rf_wa     = dec.rd;
        bus.rf_wd     = result;
        bus.alu_op    = OP_MV;

        case (state)
            ST_FETCH: begin
                // The state register resets to FETCH, so the request is masked while reset is held.
                bus.imem_req = !rst;
                if (bus.imem_ack) begin
                    ir_next    = bus.imem_data;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    illegal_next = 1'b1;
                    state_next   = ST_HALT;
                end else begin
                    wait_cnt_next = wait_cnt + 32'd1;
                end
            end
            ST_DECODE: begin
                case (dec.cls)
                    CLS_ALU:  state_next = ST_EXEC;
                    CLS_LDI:  state_next = ST_WB;
                    CLS_JUMP: begin
                        pc_next    = jump_taken ? PC_W'(dec.imm) : pc + PC_W'(1);
                        state_next = ST_FETCH;
                    end
                    CLS_HALT: state_next = ST_HALT;
                    default: begin
                        illegal_next = 1'b1;
                        state_next   = ST_HALT;
                    end
                endcase
            end
            ST_EXEC: begin
                bus.alu_op  = dec.op;
                result_next = bus.alu_out;
                state_next  = ST_WB;
            end
            ST_WB: begin
                bus.rf_we  = 1'b1;
                bus.rf_wd  = (dec.cls == CLS_LDI) ? {8'h00, dec.imm} : result;
                pc_next    = pc + PC_W'(1);
                state_next = ST_FETCH;
            end
            ST_HALT: ;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            result   <= '0;
            illegal  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
            state    <= state_next;
            pc       <= pc_next;
            ir       <= ir_next;
            result   <= result_next;
            illegal  <= illegal_next;
            wait_cnt <= wait_cnt_next;
        end
    end

endmodule

// File: tb/tb_toycpu_ctrl.sv
// Bench for toycpu_ctrl: memory/register-file/ALU environment plus an
// instruction-level reference model, directed programs and random programs.
module tb_toycpu_ctrl;

    localparam int PC_W = 8;
    localparam logic [5:0] I_ADD  = 6'd0;
    localparam logic [5:0] I_LDI  = 6'd1;
    localparam logic [5:0] I_JZ   = 6'd2;
    localparam logic [5:0] I_JC   = 6'd3;
    localparam logic [5:0] I_JMP  = 6'd4;
    localparam logic [5:0] I_HALT = 6'd5;
    localparam logic [5:0] I_MV   = 6'd63;
    localparam logic [15:0] JUNK  = 16'h1C00;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            illegal;
    int              checks = 0;
    int              errors = 0;

    toycpu_if #(.PC_W(PC_W)) bus ();

    toycpu_ctrl #(.PC_W(PC_W), .FETCH_TIMEOUT(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0]     imem [256];
    logic [15:0]     rf [4];
    logic            c_q, z_q;
    logic [16:0]     sum;
    int              ack_delay = 0;
    bit              junk_en = 1'b0;
    int              req_age;
    int              last_req_len;
    bit              addr_moved;
    logic [PC_W-1:0] first_addr;
    logic [17:0]     wr_log [128];
    logic [PC_W-1:0] fetch_log [128];
    int              wr_cnt, fetch_cnt, cyc, add_cnt;
    int              bad_cnt = 0;

    logic [17:0]     exp_wr [$];
    logic [PC_W-1:0] exp_fetch [$];
    logic [PC_W-1:0] exp_pc;
    logic            exp_ill, exp_c, exp_z;
    int              exp_cyc, exp_adds;

    assign sum         = {1'b0, rf[bus.rf_ra1]} + {1'b0, rf[bus.rf_ra2]};
    assign bus.alu_out = (bus.alu_op == I_ADD) ? sum[15:0] : rf[bus.rf_ra2];
    assign bus.c_flag  = c_q;
    assign bus.z_flag  = z_q;

    // Register file, registered ALU flags and event logs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            c_q <= 1'b0; z_q <= 1'b0;
            wr_cnt <= 0; fetch_cnt <= 0; cyc <= 0; add_cnt <= 0;
        end else begin
            if (bus.rf_we) begin
                rf[bus.rf_wa] <= bus.rf_wd;
                wr_log[wr_cnt[6:0]] <= {bus.rf_wa, bus.rf_wd};
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.alu_op == I_ADD) begin
                c_q <= sum[16];
                z_q <= (sum[15:0] == 16'h0000);
                add_cnt <= add_cnt + 1;
            end
            if (bus.imem_req && bus.imem_ack) begin
                fetch_log[fetch_cnt[6:0]] <= bus.imem_addr;
                fetch_cnt <= fetch_cnt + 1;
            end
            if (!halted) cyc <= cyc + 1;
        end
    end

    always @(posedge clk) begin
        if ((bus.rf_we && bus.imem_req) || (halted && (bus.rf_we || bus.imem_req)) ||
            (rst && (bus.rf_we || bus.imem_req)))
            bad_cnt <= bad_cnt + 1;
    end

    // Instruction memory: ack after ack_delay waiting cycles; optional stray acks outside fetch.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            bus.imem_ack = 1'b0; bus.imem_data = '0;
            req_age = 0; last_req_len = 0; addr_moved = 1'b0;
        end else if (bus.imem_req) begin
            if (req_age == 0) first_addr = bus.imem_addr;
            else if (bus.imem_addr !== first_addr) addr_moved = 1'b1;
            if (req_age >= ack_delay) begin
                bus.imem_ack = 1'b1; bus.imem_data = imem[bus.imem_addr];
                last_req_len = req_age + 1; req_age = 0;
            end else begin
                bus.imem_ack = 1'b0; req_age++;
            end
        end else begin
            bus.imem_ack = junk_en; bus.imem_data = JUNK; req_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins_r(input logic [5:0] op, input logic [1:0] rd, input logic [1:0] rs);
        return {op, rd, rs, 6'd0};
    endfunction

    function automatic logic [15:0] ins_i(input logic [5:0] op, input logic [1:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = ins_r(I_HALT, 2'd0, 2'd0);
    endtask

    // Instruction-level interpreter: architectural effects plus cycle cost per instruction.
    task automatic model_run(input int d);
        logic [15:0]     r [4];
        logic            c, z;
        logic [PC_W-1:0] p;
        logic [15:0]     w;
        logic [16:0]     s;
        logic [1:0]      rd, rs;
        logic [7:0]      imm;
        bit              done;
        for (int i = 0; i < 4; i++) r[i] = '0;
        c = 1'b0; z = 1'b0; p = '0; done = 1'b0;
        exp_wr.delete(); exp_fetch.delete();
        exp_cyc = 0; exp_ill = 1'b0; exp_adds = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            w = imem[p]; exp_fetch.push_back(p);
            rd = w[9:8]; rs = w[7:6]; imm = w[7:0];
            exp_cyc += d + 2;
            case (w[15:10])
                I_ADD: begin
                    s = {1'b0, r[rd]} + {1'b0, r[rs]};
                    r[rd] = s[15:0]; c = s[16]; z = (s[15:0] == 16'h0000);
                    exp_adds++; exp_wr.push_back({rd, r[rd]}); exp_cyc += 2; p = p + 1'b1;
                end
                I_MV:  begin r[rd] = r[rs]; exp_wr.push_back({rd, r[rd]}); exp_cyc += 2; p = p + 1'b1; end
                I_LDI: begin r[rd] = {8'h00, imm}; exp_wr.push_back({rd, r[rd]}); exp_cyc += 1; p = p + 1'b1; end
                I_JZ:  p = z ? PC_W'(imm) : p + 1'b1;
                I_JC:  p = c ? PC_W'(imm) : p + 1'b1;
                I_JMP: p = PC_W'(imm);
                I_HALT: done = 1'b1;
                default: begin exp_ill = 1'b1; done = 1'b1; end
            endcase
        end
        exp_pc = p; exp_c = c; exp_z = z;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int d, input bit junk);
        ack_delay = d; junk_en = junk;
        model_run(d);
        apply_reset();
        for (int i = 0; i < exp_cyc + 40 && !halted; i++) @(negedge clk);
        check({tag, ".halted"},  32'(halted), 32'd1);
        check({tag, ".cycles"},  32'(cyc), 32'(exp_cyc));
        check({tag, ".pc"},      32'(pc), 32'(exp_pc));
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        check({tag, ".nwr"},     32'(wr_cnt), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_cnt && i < 128; i++)
            check($sformatf("%s.wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
        check({tag, ".nfetch"},  32'(fetch_cnt), 32'(exp_fetch.size()));
        for (int i = 0; i < exp_fetch.size() && i < fetch_cnt && i < 128; i++)
            check($sformatf("%s.fetch%0d", tag, i), 32'(fetch_log[i]), 32'(exp_fetch[i]));
        check({tag, ".adds"},    32'(add_cnt), 32'(exp_adds));
        check({tag, ".flags"},   32'({c_q, z_q}), 32'({exp_c, exp_z}));
        check({tag, ".protocol"}, 32'(bad_cnt), 32'd0);
    endtask

    initial begin
        int         len, k;
        bit         found;
        logic [1:0] rd, rs;
        logic [7:0] tgt;

        fill_halt();
        #2 rst = 1'b1;
        #1;
        check("rst.imem_req", 32'(bus.imem_req), 32'd0);
        check("rst.rf_we",    32'(bus.rf_we), 32'd0);
        check("rst.alu_op",   32'(bus.alu_op), 32'd63);
        check("rst.pc",       32'(pc), 32'd0);
        check("rst.halted",   32'(halted), 32'd0);
        check("rst.illegal",  32'(illegal), 32'd0);

        // LDI/LDI/ADD/HALT
        fill_halt();
        imem[0] = ins_i(I_LDI, 2'd0, 8'd5);
        imem[1] = ins_i(I_LDI, 2'd1, 8'd3);
        imem[2] = ins_r(I_ADD, 2'd0, 2'd1);
        imem[3] = ins_r(I_HALT, 2'd0, 2'd0);
        run_prog("p_add", 0, 1'b0);
        check("p_add.r0",    32'(wr_log[2]), 32'({2'd0, 16'd8}));
        check("p_add.pc3",   32'(pc), 32'd3);
        check("p_add.z",     32'(z_q), 32'd0);

        // zero sum then JZ taken
        fill_halt();
        imem[0] = ins_i(I_LDI, 2'd0, 8'd0);
        imem[1] = ins_i(I_LDI, 2'd1, 8'd0);
        imem[2] = ins_r(I_ADD, 2'd0, 2'd1);
        imem[3] = ins_i(I_JZ, 2'd0, 8'h10);
        run_prog("p_jz", 0, 1'b0);
        check("p_jz.target", 32'(fetch_log[4]), 32'h10);

        // 0xFFFF + 1 carries into JC taken, then JC not taken after a carry-free ADD
        fill_halt();
        imem[0] = ins_i(I_LDI, 2'd0, 8'hFF);
        imem[1] = ins_i(I_LDI, 2'd1, 8'hFF);
        for (int i = 2; i < 10; i++) imem[i] = ins_r(I_ADD, 2'd0, 2'd0);
        imem[10] = ins_r(I_ADD, 2'd0, 2'd1);
        imem[11] = ins_i(I_LDI, 2'd1, 8'd1);
        imem[12] = ins_r(I_ADD, 2'd0, 2'd1);
        imem[13] = ins_i(I_JC, 2'd0, 8'h20);
        imem[32] = ins_r(I_ADD, 2'd2, 2'd2);
        imem[33] = ins_i(I_JC, 2'd0, 8'h30);
        run_prog("p_jc", 1, 1'b0);
        check("p_jc.ffff",   32'(wr_log[10]), 32'({2'd0, 16'hFFFF}));
        check("p_jc.wrap0",  32'(wr_log[12]), 32'({2'd0, 16'h0000}));
        check("p_jc.taken",  32'(fetch_log[14]), 32'h20);
        check("p_jc.pc",     32'(pc), 32'h22);

        // slow memory plus stray acks outside fetch
        fill_halt();
        imem[0] = ins_i(I_LDI, 2'd0, 8'd1);
        imem[1] = ins_r(I_ADD, 2'd0, 2'd0);
        run_prog("p_wait", 3, 1'b1);
        check("p_wait.reqlen", 32'(last_req_len), 32'd4);
        check("p_wait.stable", 32'(addr_moved), 32'd0);

        // PC wrap through 0xFF and an illegal opcode
        fill_halt();
        imem[0]   = ins_i(I_JZ, 2'd0, 8'h10);
        imem[1]   = ins_r(I_ADD, 2'd3, 2'd3);
        imem[2]   = ins_i(I_JMP, 2'd0, 8'hFF);
        imem[255] = ins_r(I_MV, 2'd1, 2'd0);
        imem[16]  = ins_r(6'd7, 2'd0, 2'd0);
        run_prog("p_wrap", 1, 1'b1);
        check("p_wrap.ff",   32'(fetch_log[3]), 32'hFF);
        check("p_wrap.00",   32'(fetch_log[4]), 32'h00);
        check("p_wrap.ill",  32'(illegal), 32'd1);
        check("p_wrap.nwr",  32'(wr_cnt), 32'd2);

        // reset asserted during the write-back of ADD
        fill_halt();
        imem[0] = ins_i(I_LDI, 2'd0, 8'd5);
        imem[1] = ins_i(I_LDI, 2'd1, 8'd3);
        imem[2] = ins_r(I_ADD, 2'd0, 2'd1);
        ack_delay = 0; junk_en = 1'b0;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.rf_we && wr_cnt == 2) found = 1'b1;
        end
        check("p_rst.inwb", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("p_rst.we",   32'(bus.rf_we), 32'd0);
        check("p_rst.req",  32'(bus.imem_req), 32'd0);
        check("p_rst.pc",   32'(pc), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("p_rst.req1", 32'(bus.imem_req), 32'd1);
        check("p_rst.addr", 32'(bus.imem_addr), 32'd0);
        check("p_rst.nwr",  32'(wr_cnt), 32'd0);
        check("p_rst.prot", 32'(bad_cnt), 32'd0);

        // random forward-branching programs ending in HALT
        for (int t = 0; t < 10; t++) begin
            fill_halt();
            len = $urandom_range(6, 20);
            for (int i = 0; i < len - 1; i++) begin
                k   = $urandom_range(0, 99);
                rd  = 2'($urandom);
                rs  = 2'($urandom);
                tgt = 8'($urandom_range(i + 1, len - 1));
                if (k < 30)      imem[i] = ins_i(I_LDI, rd, 8'($urandom));
                else if (k < 55) imem[i] = ins_r(I_ADD, rd, rs);
                else if (k < 65) imem[i] = ins_r(I_MV, rd, rs);
                else if (k < 75) imem[i] = ins_i(I_JZ, rd, tgt);
                else if (k < 85) imem[i] = ins_i(I_JC, rd, tgt);
                else if (k < 95) imem[i] = ins_i(I_JMP, rd, tgt);
                else             imem[i] = ins_r(6'($urandom_range(6, 62)), rd, rs);
            end
            run_prog($sformatf("rnd%0d", t), $urandom_range(0, 2), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toycpu_ctrl.md
TOYCPU_CTRL -- requirements
Module: toycpu_ctrl

Interface
REQ-001 Parameter PC_W, default 8, program counter and instruction address width.
REQ-002 Parameter FETCH_TIMEOUT, default 0, disables the fetch timeout; when N>0, FETCH waiting N cycles without ack SHALL set illegal and halt.
REQ-003 clk  in  1  clock; all state SHALL update on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req  out  1  instruction fetch request; imem_addr  out  PC_W  fetch address.
REQ-006 imem_ack  in  1  fetch complete; imem_data  in  16  instruction, valid when imem_ack=1.
REQ-007 rf_ra1, rf_ra2  out  2 each  register-file read addresses (rd, rs).
REQ-008 rf_we  out  1  write strobe; rf_wa  out  2  write address; rf_wd  out  16  write data.
REQ-009 alu_op  out  6  ALU opcode; alu_out  in  16  ALU result.
REQ-010 c_flag, z_flag  in  1 each  registered ALU flags.
REQ-011 pc  out  PC_W  current PC; halted  out  1; illegal  out  1.

Function
REQ-012 Instruction format SHALL be op[15:10], rd[9:8], rs[7:6], imm8/target[7:0].
REQ-013 Opcodes SHALL be: 0 ADD (rd=rd+rs, flags update); 63 MV (rd=rs); 1 LDI (rd=zero-extended imm8); 2 JZ, 3 JC, 4 JMP (absolute target[PC_W-1:0]); 5 HALT; all others illegal.
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT.
REQ-015 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack, IR latches imem_data and state goes to DECODE; imem_ack outside FETCH is ignored.
REQ-016 DECODE: ADD/MV -> EXEC; LDI -> WB; JZ/JC/JMP -> FETCH with pc=target if taken (JZ on z_flag=1, JC on c_flag=1, JMP always), else pc+1; HALT -> HALT; illegal -> HALT with illegal=1.
REQ-017 EXEC: alu_op=IR op for exactly one cycle; rf_ra1=rd, rf_ra2=rs; alu_out captured into a result register; next WB.
REQ-018 WB: rf_we=1 for exactly one cycle, rf_wa=rd, rf_wd=result register (ADD/MV) or {8'h00,imm8} (LDI); pc=pc+1; next FETCH.
REQ-019 In every state except EXEC alu_op SHALL be 63 (MV) so the ALU flags hold.
REQ-020 Flags from an ADD SHALL be visible to a JZ/JC immediately following it.
REQ-021 pc SHALL wrap from 2^PC_W-1 to 0 with no status change.
REQ-022 Latency with zero-wait ack: ADD/MV 4 cycles, LDI 3, jump 2 (taken or not).
REQ-023 HALT: imem_req=0, rf_we=0, halted=1; exit only by reset.
REQ-024 rf_we SHALL never assert outside WB; imem_req never outside FETCH.

Reset
REQ-025 On rst: state=FETCH, pc=0, IR=0, result=0, halted=0, illegal=0, imem_req drops at once, rf_we=0, alu_op=63.
REQ-026 Reset during any state, including mid-fetch or WB, SHALL abort with no register write; first fetch after release is address 0.

Structure
REQ-027 Package toycpu_pkg SHALL hold opcode constants (ADD=0, LDI=1, JZ=2, JC=3, JMP=4, HALT=5, MV=63), the FSM state enum and the instruction field positions.
REQ-028 A combinational sub-module toycpu_decode SHALL map IR to class (alu, ldi, jump, halt, illegal) and fields.

Verification
REQ-029 LDI r0,#5; LDI r1,#3; ADD r0,r1; HALT -> rf writes r0=5, r1=3, r0=8; halted=1 at pc=3; z_flag=0.
REQ-030 LDI r0,#0; LDI r1,#0; ADD r0,r1; JZ 0x10 -> next fetch address 0x10.
REQ-031 r0=0xFFFF via ADD chain, r1=1, ADD r0,r1; JC 0x20 -> r0=0, c_flag=1, z_flag=1, fetch 0x20; JC not taken when c_flag=0 -> pc+1.
REQ-032 imem_ack delayed 3 cycles -> imem_addr stable and imem_req high for 4 cycles; ack pulse during DECODE ignored.
REQ-033 JMP 0xFF then MV at 0xFF -> next fetch 0x00; opcode 7 -> illegal=1, halted=1, no rf_we.
REQ-034 rst asserted in WB of ADD -> no rf_we, pc=0, imem_req next at address 0 after release.
